bip_debug_tx: RTL

//   Downstream consumer of the bip top level: watches o_Halt/o_ACC, counts clock cycles the

---
 rtl/bip_debug_tx.sv | 107 ++++++++++
 1 files changed

// File: rtl/bip_debug_tx.sv
// Debug frame transmitter for the bip core: counts run cycles until halt, then
// streams {0xA5, ACC, CNT, XOR checksum} MSB-first to a UART TX over start/done.
module bip_debug_tx #(
  parameter int NBITS_D   = 16,
  parameter int NBITS_CNT = 16,
  parameter int NBITS_B   = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_Halt,
  input  logic [NBITS_D-1:0] i_ACC,
  input  logic               i_TxDone,
  output logic               o_TxStart,
  output logic [NBITS_B-1:0] o_TxData,
  output logic               o_Busy,
  output logic               o_Done
);

  localparam int N_ACC   = NBITS_D / 8;
  localparam int N_CNT   = NBITS_CNT / 8;
  localparam int N_BYTES = N_ACC + N_CNT + 2;
  localparam int IDX_W   = $clog2(N_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0]       HEADER   = 8'hA5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  logic [1:0]             state;
  logic [NBITS_CNT-1:0]   counter;
  logic [NBITS_D-1:0]     acc_q;
  logic [NBITS_CNT-1:0]   cnt_q;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       next_idx;
  logic [7:0]             chk;
  logic [7:0]             next_byte;
  logic [N_BYTES*8-1:0]   frame_bits;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    chk = '0;
    for (int i = 0; i < N_ACC; i++) chk = chk ^ acc_q[i*8 +: 8];
    for (int i = 0; i < N_CNT; i++) chk = chk ^ cnt_q[i*8 +: 8];
  end

  assign frame_bits = {HEADER, acc_q, cnt_q, chk};
  assign next_idx   = idx + 1'b1;

  always_comb begin
    next_byte = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      if (next_idx == IDX_W'(i)) next_byte = frame_bits[(N_BYTES-1-i)*8 +: 8];
    end
  end

  // o_TxData is loaded on the edge that enters SEND, so the byte is already
  // valid during the start pulse and held until the matching done.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= S_IDLE;
      counter  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      idx      <= '0;
      o_TxData <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_Halt) begin
            acc_q    <= i_ACC;
            cnt_q    <= counter;
            idx      <= '0;
            o_TxData <= NBITS_B'(HEADER);
            state    <= S_SEND;
          end else if (counter != '1) begin
            counter <= counter + 1'b1;
          end
        end
        S_SEND: state <= S_WAIT;
        S_WAIT: begin
          if (i_TxDone) begin
            if (idx == LAST_IDX) begin
              state <= S_DONE;
            end else begin
              idx      <= next_idx;
              o_TxData <= NBITS_B'(next_byte);
              state    <= S_SEND;
            end
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_TxStart = (state == S_SEND);
  assign o_Busy    = (state == S_SEND) || (state == S_WAIT);
  assign o_Done    = (state == S_DONE);

endmodule
